ws2812_frame_scheduler: RTL and testbench
=========================================

WS2812_FRAME_SCHEDULER -- requirements
Module: ws2812_frame_scheduler

Interface
REQ-001 SHALL have parameter LEDS, default 11: number of LEDs in the chain.
REQ-002 SHALL have parameter INTERPOLATIONS, default 4: LEDs per milestone span; power of two, at least 2.
REQ-003 SHALL have parameter HOLDOFF_CYCLES, default 1024: idle clocks after a frame before the next trigger (latch gap).
REQ-004 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  permits starting new frames.
REQ-007 SHALL have port data_request  input  1  one-cycle pulse from the WS2812 driver consuming the current byte.
REQ-008 SHALL have port color_in  input  24  new milestone colour {G,R,B}, sampled only while color_req is high.
REQ-009 SHALL have port color_req  output  1  one-cycle pulse; color_in is captured on the same edge.
REQ-010 SHALL have port trigger  output  1  one-cycle pulse starting driver transmission.
REQ-011 SHALL have port data_valid  output  1  byte_out is meaningful; low in IDLE, LOAD and HOLDOFF.
REQ-012 SHALL have port byte_out  output  8  pre-gamma interpolated colour byte.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse on the edge entering HOLDOFF.

Function
REQ-014 SHALL hold M = floor((LEDS+INTERPOLATIONS-2)/INTERPOLATIONS)+2 milestone colours of 24 bits (5 for the defaults), plus frame phase p in 0..INTERPOLATIONS-1.
REQ-015 SHALL implement FSM IDLE -> LOAD -> STREAM -> HOLDOFF -> (LOAD if enable, else IDLE); IDLE -> LOAD when enable is high.
REQ-016 LOAD SHALL last exactly one cycle and assert trigger; if p==0, it SHALL also assert color_req, shift milestone[i] <= milestone[i+1] and set milestone[M-1] <= color_in.
REQ-017 STREAM SHALL walk LED index n = 0..LEDS-1 and byte index c = G,R,B; each data_request advances (n,c) by one byte; data_valid is high throughout STREAM.
REQ-018 For LED n: s = n+p, k = s mod INTERPOLATIONS, j = s / INTERPOLATIONS; byte_out = (A*(INTERPOLATIONS-k) + B*k) / INTERPOLATIONS, truncated, where A and B are channel c of milestone[j] and milestone[j+1].
REQ-019 The lerp product-sum SHALL be 8+log2(INTERPOLATIONS)+1 bits wide with no overflow; the result always fits in 8 bits.
REQ-020 byte_out SHALL present the first byte (n=0, G) on the cycle trigger is high and the next byte on the cycle after each data_request.
REQ-021 A data_request on the last byte (n=LEDS-1, B) SHALL move to HOLDOFF, pulse frame_done and advance p modulo INTERPOLATIONS.
REQ-022 HOLDOFF SHALL last exactly HOLDOFF_CYCLES clocks; data_request is ignored in IDLE, LOAD and HOLDOFF.
REQ-023 enable deasserted mid-frame SHALL not abort the frame; the frame and HOLDOFF complete, then the FSM enters IDLE.
REQ-024 trigger, color_req and frame_done SHALL never be high in the same cycle except trigger with color_req in LOAD.

Reset
REQ-025 RST high SHALL asynchronously force IDLE, p=0, all milestones=0, all counters=0, and trigger, color_req, data_valid, frame_done and byte_out to 0.
REQ-026 Reset mid-STREAM SHALL abandon the frame; after release, the first trigger appears no earlier than 2 cycles after enable is sampled high.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the byte-order constants (G=0, R=1, B=2) and the milestone-count function.
REQ-028 The per-channel interpolation SHALL be a combinational sub-module milestone_lerp (inputs A, B and k; output byte); the gamma stage stays downstream and outside this block.

Verification
REQ-029 Reset, enable=1, color_in=0x4080C0 held, driver model answers every request -> after 20 frames every LED streams bytes 0x40, 0x80, 0xC0; 33 data_request pulses per frame; trigger period = 33 request cycles + HOLDOFF_CYCLES + 1.
REQ-030 Milestones preloaded to 0x000000 then 0xFFFFFF..., p=1 -> LED0 G byte = (0*3+255*1)/4 = 0x3F; LED3 G byte = 0xFF.
REQ-031 Over 8 consecutive frames, color_req pulses exactly on frames 0 and 4 (p==0), coincident with trigger.
REQ-032 data_request pulses injected during HOLDOFF and IDLE -> no change to byte_out, n, c or p.
REQ-033 RST asserted at n=5 mid-STREAM -> data_valid and byte_out are 0 on the same cycle, asynchronously; the next frame starts at n=0, p=0 with all-zero bytes.
REQ-034 enable dropped at n=2 -> the frame completes all 33 bytes, frame_done pulses, and there is no further trigger.

Source files
------------

// File: rtl/ws2812_frame_scheduler_pkg.sv
// Shared types and helpers for the WS2812 frame scheduler: FSM states,
// byte order within an LED word, and milestone storage sizing.
package ws2812_frame_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_STREAM  = 2'd2,
      ST_HOLDOFF = 2'd3
   } state_e;

   localparam logic [1:0] BYTE_G = 2'd0;
   localparam logic [1:0] BYTE_R = 2'd1;
   localparam logic [1:0] BYTE_B = 2'd2;

   // Enough milestones that LED LEDS-1 at the largest phase still has a right neighbour.
   function automatic int milestone_count(input int leds, input int interp);
      return (leds + interp - 2) / interp + 2;
   endfunction

   function automatic logic [7:0] chan_byte(input logic [23:0] col, input logic [1:0] c);
      case (c)
         BYTE_G:  return col[23:16];
         BYTE_R:  return col[15:8];
         default: return col[7:0];
      endcase
   endfunction

endpackage

// File: rtl/ws2812_frame_scheduler_lerp.sv
// Combinational linear blend of one colour channel between two milestones,
// weight k/INTERPOLATIONS towards b_i.
module milestone_lerp #(
   parameter int INTERPOLATIONS = 4
) (
   input  logic [7:0]                        a_i,
   input  logic [7:0]                        b_i,
   input  logic [$clog2(INTERPOLATIONS)-1:0] k_i,
   output logic [7:0]                        byte_o
);
   localparam int KW = $clog2(INTERPOLATIONS);
   localparam int SW = 8 + KW + 1;

   logic [KW:0]   wa;
   logic [SW-1:0] sum;

   assign wa     = (KW+1)'(INTERPOLATIONS) - {1'b0, k_i};
   assign sum    = SW'(a_i) * SW'(wa) + SW'(b_i) * SW'(k_i);
   assign byte_o = 8'(sum >> KW);

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Streams interpolated colour bytes for a WS2812 chain, scrolling between
// milestone colours one LED per frame and pacing frames with a latch gap.
module ws2812_frame_scheduler
   import ws2812_frame_scheduler_pkg::*;
#(
   parameter int LEDS           = 11,
   parameter int INTERPOLATIONS = 4,
   parameter int HOLDOFF_CYCLES = 1024
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        enable,
   input  logic        data_request,
   input  logic [23:0] color_in,
   output logic        color_req,
   output logic        trigger,
   output logic        data_valid,
   output logic [7:0]  byte_out,
   output logic        frame_done
);
   localparam int M  = milestone_count(LEDS, INTERPOLATIONS);
   localparam int KW = $clog2(INTERPOLATIONS);
   localparam int NW = $clog2(LEDS + 1);
   localparam int SW = $clog2(LEDS + INTERPOLATIONS);
   localparam int JW = SW - KW;
   localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

   state_e              state_q, state_d;
   logic [NW-1:0]       n_q, n_d;
   logic [1:0]          c_q, c_d;
   logic [KW-1:0]       p_q, p_d;
   logic [HW-1:0]       hcnt_q, hcnt_d;
   logic [M-1:0][23:0]  ms_q, ms_d;
   logic                enable_q;
   logic                frame_done_q, frame_done_d;

   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      c_d          = c_q;
      p_d          = p_q;
      hcnt_d       = hcnt_q;
      ms_d         = ms_q;
      frame_done_d = 1'b0;
      case (state_q)
         ST_IDLE: if (enable_q) state_d = ST_LOAD;
         ST_LOAD: begin
            state_d = ST_STREAM;
            n_d     = '0;
            c_d     = BYTE_G;
            if (p_q == '0) begin
               for (int i = 0; i < M-1; i++) ms_d[i] = ms_q[i+1];
               ms_d[M-1] = color_in;
            end
         end
         ST_STREAM: if (data_request) begin
            if (c_q == BYTE_B) begin
               c_d = BYTE_G;
               if (n_q == NW'(LEDS-1)) begin
                  state_d      = ST_HOLDOFF;
                  frame_done_d = 1'b1;
                  p_d          = p_q + 1'b1;
                  n_d          = '0;
                  hcnt_d       = '0;
               end else begin
                  n_d = n_q + 1'b1;
               end
            end else begin
               c_d = c_q + 2'd1;
            end
         end
         ST_HOLDOFF: begin
            if (hcnt_q == HW'(HOLDOFF_CYCLES-1)) begin
               state_d = enable_q ? ST_LOAD : ST_IDLE;
               hcnt_d  = '0;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         n_q          <= '0;
         c_q          <= BYTE_G;
         p_q          <= '0;
         hcnt_q       <= '0;
         ms_q         <= '0;
         enable_q     <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         c_q          <= c_d;
         p_q          <= p_d;
         hcnt_q       <= hcnt_d;
         ms_q         <= ms_d;
         enable_q     <= enable;
         frame_done_q <= frame_done_d;
      end
   end

   // ms_d equals ms_q except in LOAD, where it already holds the shifted
   // milestones so the first byte is correct on the trigger cycle.
   logic [SW-1:0] s;
   logic [JW-1:0] j;
   logic [7:0]    lerp_a, lerp_b, lerp_y;

   assign s = SW'(n_q) + SW'(p_q);
   assign j = s[SW-1:KW];

   always_comb begin
      lerp_a = '0;
      lerp_b = '0;
      for (int i = 0; i < M-1; i++) begin
         if (j == JW'(i)) begin
            lerp_a = chan_byte(ms_d[i],   c_q);
            lerp_b = chan_byte(ms_d[i+1], c_q);
         end
      end
   end

   milestone_lerp #(.INTERPOLATIONS(INTERPOLATIONS)) u_lerp (
      .a_i    (lerp_a),
      .b_i    (lerp_b),
      .k_i    (s[KW-1:0]),
      .byte_o (lerp_y)
   );

   assign trigger    = (state_q == ST_LOAD);
   assign color_req  = trigger && (p_q == '0);
   assign data_valid = (state_q == ST_STREAM);
   assign frame_done = frame_done_q;
   assign byte_out   = (trigger || data_valid) ? lerp_y : 8'h00;

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Directed/random bench for ws2812_frame_scheduler with a milestone/phase
// reference model computed from the interpolation rules.
module tb_ws2812_frame_scheduler;
   localparam int LEDS   = 11;
   localparam int INTERP = 4;
   localparam int HOLD   = 40;
   localparam int M      = (LEDS + INTERP - 2) / INTERP + 2;
   localparam int NB     = LEDS * 3;

   logic        CLK = 1'b0;
   logic        RST, enable, data_request;
   logic [23:0] color_in;
   logic        color_req, trigger, data_valid, frame_done;
   logic [7:0]  byte_out;

   ws2812_frame_scheduler #(.LEDS(LEDS), .INTERPOLATIONS(INTERP), .HOLDOFF_CYCLES(HOLD)) dut (
      .CLK(CLK), .RST(RST), .enable(enable), .data_request(data_request),
      .color_in(color_in), .color_req(color_req), .trigger(trigger),
      .data_valid(data_valid), .byte_out(byte_out), .frame_done(frame_done)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int          errors = 0;
   int          checks = 0;
   logic [23:0] ms [M];
   int          p;
   logic [7:0]  got [NB];
   int          last_trig = -1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fail_now(input string tag);
      checks++;
      errors++;
      $error("FAIL %s observed=timeout expected=event", tag);
   endtask

   task automatic model_reset();
      for (int i = 0; i < M; i++) ms[i] = 24'h0;
      p = 0;
   endtask

   function automatic int exp_byte(input int n, input int c);
      int s, k, j, a, b;
      s = n + p;
      k = s % INTERP;
      j = s / INTERP;
      a = int'((ms[j]   >> (8 * (2 - c))) & 24'hFF);
      b = int'((ms[j+1] >> (8 * (2 - c))) & 24'hFF);
      return (a * (INTERP - k) + b * k) / INTERP;
   endfunction

   // Waits for trigger while injecting stray requests; everything must stay quiet.
   task automatic wait_trigger(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < HOLD + 200; i++) begin
         @(negedge CLK);
         if (trigger) begin
            ok = 1'b1;
            break;
         end
         check("quiet", {data_valid, color_req, frame_done, byte_out}, 32'h0);
         data_request = 1'($urandom_range(0, 1));
      end
      if (!ok) fail_now("trigger_timeout");
   endtask

   task automatic run_frame(input logic [23:0] col, input bit gaps, input int drop_at,
                            input int rst_at, input bit chk_period);
      bit ok;
      int b;
      color_in = col;
      wait_trigger(ok);
      if (!ok) return;
      if (chk_period && last_trig >= 0) check("trig_period", 32'(cyc - last_trig), 32'(NB + HOLD + 1));
      last_trig = cyc;
      check("color_req", 32'(color_req), 32'(p == 0));
      check("dv_load", 32'(data_valid), 32'h0);
      if (p == 0) begin
         for (int i = 0; i < M-1; i++) ms[i] = ms[i+1];
         ms[M-1] = col;
      end
      check("byte_load", 32'(byte_out), 32'(exp_byte(0, 0)));
      b = 0;
      for (int g = 0; g < 8 * NB && b < NB; g++) begin
         @(negedge CLK);
         if (b == rst_at) begin
            #1 RST = 1'b1;
            #1;
            check("rst_dv", 32'(data_valid), 32'h0);
            check("rst_byte", 32'(byte_out), 32'h0);
            data_request = 1'b0;
            model_reset();
            @(negedge CLK);
            RST = 1'b0;
            last_trig = -1;
            return;
         end
         check("stream_dv", 32'(data_valid), 32'h1);
         check("stream_byte", 32'(byte_out), 32'(exp_byte(b / 3, b % 3)));
         got[b] = byte_out;
         if (b == drop_at) enable = 1'b0;
         data_request = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (data_request) b++;
      end
      if (b < NB) begin
         fail_now("stream_timeout");
         return;
      end
      @(negedge CLK);
      data_request = 1'b0;
      check("frame_done", 32'(frame_done), 32'h1);
      check("hold_dv", {trigger, data_valid, byte_out}, 32'h0);
      p = (p + 1) % INTERP;
   endtask

   initial begin
      RST = 1'b1; enable = 1'b0; data_request = 1'b0; color_in = 24'h0;
      model_reset();
      repeat (3) @(negedge CLK);
      check("rst_out", {trigger, color_req, data_valid, frame_done, byte_out}, 32'h0);
      RST = 1'b0;
      enable = 1'b1;

      // 0 then all-ones milestones; frame 17 runs with p=1
      for (int f = 0; f < 18; f++) run_frame((f == 0) ? 24'h0 : 24'hFFFFFF, 1'b0, -1, -1, f > 0);
      check("p1_led0_g", 32'(got[0]), 32'h3F);
      check("p1_led3_g", 32'(got[9]), 32'hFF);

      for (int f = 0; f < 8; f++) run_frame(24'($urandom), 1'b1, -1, -1, 1'b0);

      for (int f = 0; f < 20; f++) run_frame(24'h4080C0, 1'b0, -1, -1, f > 0);
      for (int b = 0; b < NB; b++)
         check("const_bytes", 32'(got[b]), (b % 3 == 0) ? 32'h40 : (b % 3 == 1) ? 32'h80 : 32'hC0);

      // reset at LED 5, G byte
      run_frame(24'h123456, 1'b0, -1, 15, 1'b0);
      run_frame(24'hABCDEF, 1'b0, -1, -1, 1'b0);
      for (int b = 0; b < NB; b++) check("post_rst_zero", 32'(got[b]), 32'h0);

      // enable drop at LED 2
      run_frame(24'($urandom), 1'b0, 6, -1, 1'b0);
      for (int i = 0; i < HOLD + 20; i++) begin
         @(negedge CLK);
         check("no_trigger", {trigger, data_valid, color_req, byte_out}, 32'h0);
         data_request = 1'($urandom_range(0, 1));
      end
      enable = 1'b1;
      run_frame(24'($urandom), 1'b1, -1, -1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
